// File: rtl/sdm_sample_feeder.sv
// Sample FIFO and release timer feeding the sdm_2o modulator input.
// Define SDM_FEEDER_LINEAR_INTERP_EN to ramp linearly between samples instead of zero-order hold.
module sdm_sample_feeder #(
    parameter int DW = 16,
    parameter int AW = 3,
    parameter int CW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    osr_log2,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_strobe,
    output logic [AW:0]   level,
    output logic          underflow,
    input  logic          underflow_clr
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] out_data_r;
    logic          out_strobe_r;
    logic          underflow_r;

    logic [CW-1:0] mask_s;
    logic          tick_s;
    logic          push_s;
    logic          pop_s;
    logic          in_ready_s;
    logic [DW-1:0] head_s;

`ifdef SDM_FEEDER_LINEAR_INTERP_EN
    logic [DW-1:0]        tgt_r;
    logic signed [DW:0]   step_r;
    logic signed [DW:0]   diff_s;
    logic signed [DW+1:0] sum_s;
    logic signed [DW+1:0] tgt_ext_s;
    logic [DW-1:0]        ramp_s;
`endif

    // Release period mask: low osr_log2 bits set, saturating at CW bits.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < CW; i++) begin
            if (i < int'(osr_log2)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
    end

    // in_ready looks only at registered occupancy, so a same-cycle pop never frees a full FIFO.
    assign in_ready_s = (level_r != FULL_LVL);
    assign tick_s     = en && ((cnt_r & mask_s) == mask_s);
    assign push_s     = in_valid && in_ready_s;
    assign pop_s      = tick_s && (level_r != '0);
    assign head_s     = mem_r[rd_ptr_r];

    assign in_ready   = in_ready_s;
    assign out_data   = out_data_r;
    assign out_strobe = out_strobe_r;
    assign level      = level_r;
    assign underflow  = underflow_r;

`ifdef SDM_FEEDER_LINEAR_INTERP_EN
    // Next ramp value, clamped at the target so floor rounding of step cannot overshoot.
    always_comb begin
        diff_s    = $signed({1'b0, head_s}) - $signed({1'b0, tgt_r});
        sum_s     = $signed({2'b00, out_data_r}) + $signed({step_r[DW], step_r});
        tgt_ext_s = $signed({2'b00, tgt_r});
        if (!step_r[DW] && (step_r != '0) && (sum_s > tgt_ext_s)) begin
            ramp_s = tgt_r;
        end else if (step_r[DW] && (sum_s < tgt_ext_s)) begin
            ramp_s = tgt_r;
        end else begin
            ramp_s = sum_s[DW-1:0];
        end
    end
`endif

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Oversampling counter; held at zero while disabled so re-enable starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= '0;
        end
    end

    // Sticky underflow; a new empty release wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_r <= 1'b0;
        end else if (tick_s && (level_r == '0)) begin
            underflow_r <= 1'b1;
        end else if (underflow_clr) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    // Output sample register and release strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= MIDSCALE;
            out_strobe_r <= 1'b0;
`ifdef SDM_FEEDER_LINEAR_INTERP_EN
            tgt_r        <= MIDSCALE;
            step_r       <= '0;
`endif
        end else begin
            out_strobe_r <= tick_s;
            if (tick_s) begin
`ifdef SDM_FEEDER_LINEAR_INTERP_EN
                out_data_r <= tgt_r;
                if (pop_s) begin
                    tgt_r  <= head_s;
                    step_r <= diff_s >>> osr_log2;
                end else begin
                    step_r <= '0;
                end
`else
                if (pop_s) begin
                    out_data_r <= head_s;
                end else begin
                    out_data_r <= out_data_r;
                end
`endif
            end else if (en) begin
`ifdef SDM_FEEDER_LINEAR_INTERP_EN
                out_data_r <= ramp_s;
`else
                out_data_r <= out_data_r;
`endif
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

endmodule

// File: tb/tb_sdm_sample_feeder.sv
// Scoreboard bench for sdm_sample_feeder (zero-order-hold build) against a queue-based reference model.
module tb_sdm_sample_feeder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  osr_log2;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_strobe;
    logic [3:0]  level;
    logic        underflow;
    logic        underflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    sdm_sample_feeder #(.DW(16), .AW(3), .CW(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .osr_log2      (osr_log2),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_strobe    (out_strobe),
        .level         (level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        uf;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_fifo[$];
    int          m_cnt;
    logic [15:0] m_out;
    logic        m_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a release is due on every 2^osr_log2-th enabled cycle.
    always @(posedge clk or negedge rst_n) begin : model
        int period;
        bit due;
        bit was_empty;
        bit can_push;
        if (!rst_n) begin
            m_cnt = 0;
            m_fifo.delete();
            exp_q.delete();
            m_out = 16'h8000;
            m_uf  = 1'b0;
        end else begin
            period    = 1 << osr_log2;
            due       = en && (((m_cnt + 1) % period) == 0);
            was_empty = (m_fifo.size() == 0);
            can_push  = (m_fifo.size() < 8);
            if (due && was_empty) m_uf = 1'b1;
            else if (underflow_clr) m_uf = 1'b0;
            if (due) begin
                if (!was_empty) m_out = m_fifo.pop_front();
                exp_q.push_back('{data: m_out, uf: m_uf});
            end
            if (in_valid && can_push) m_fifo.push_back(in_data);
            m_cnt = en ? ((m_cnt + 1) % 32768) : 0;
        end
    end

    // Monitor: state checks every cycle, scoreboard pop on every strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("level", 32'(level), 32'(m_fifo.size()));
            chk("in_ready", 32'(in_ready), 32'(m_fifo.size() < 8));
            chk("underflow", 32'(underflow), 32'(m_uf));
            chk("out_data_hold", 32'(out_data), 32'(m_out));
            if (out_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(out_strobe), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("release_data", 32'(out_data), 32'(e.data));
                    chk("release_underflow", 32'(underflow), 32'(e.uf));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_strobe", 32'(out_strobe), 32'd1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; osr_log2 = 4'd0; in_valid = 1'b0;
        in_data = 16'h0; underflow_clr = 1'b0;
        #23;
        chk("rst_out_data", 32'(out_data), 32'h8000);
        chk("rst_strobe", 32'(out_strobe), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cycles(1);
        rst_n = 1'b1;
        cycles(2);

        // No data: midscale held, strobe every 4 cycles, underflow after first tick.
        en = 1'b1; osr_log2 = 4'd2;
        cycles(20);

        // Clear underflow with the timer off, then overfill the FIFO.
        en = 1'b0; underflow_clr = 1'b1;
        cycles(1);
        underflow_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h1111 * (i + 1));
            cycles(1);
        end
        in_valid = 1'b0;
        cycles(2);
        en = 1'b1;
        cycles(40);

        // Clear held high across an empty tick and beyond.
        underflow_clr = 1'b1;
        cycles(6);
        underflow_clr = 1'b0;
        en = 1'b0;
        cycles(1);
        underflow_clr = 1'b1;
        cycles(1);
        underflow_clr = 1'b0;

        // Three samples released four cycles apart, then underflow.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 16'(i * 16'h1000);
            cycles(1);
        end
        in_valid = 1'b0;
        en = 1'b1;
        cycles(20);

        // Push and tick together on an empty FIFO, osr_log2 = 0.
        osr_log2 = 4'd0; in_valid = 1'b1; in_data = 16'hABCD;
        cycles(1);
        in_valid = 1'b0;
        cycles(3);

        // en drop mid-period and re-enable.
        osr_log2 = 4'd3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            cycles(1);
        end
        in_valid = 1'b0;
        cycles(3);
        en = 1'b0;
        cycles(10);
        en = 1'b1;
        cycles(20);

        // Randomized traffic with a mid-run reset.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 2500; c++) begin
                en            = ($urandom % 16) != 0;
                in_valid      = ($urandom % 2) != 0;
                in_data       = 16'($urandom);
                underflow_clr = ($urandom % 16) == 0;
                if (($urandom % 32) == 0) begin
                    if (($urandom % 8) == 0) osr_log2 = 4'($urandom % 16);
                    else osr_log2 = 4'($urandom % 5);
                end
                cycles(1);
            end
            if (phase == 0) begin
                rst_n = 1'b0;
                cycles(2);
                chk("midrst_level", 32'(level), 32'd0);
                chk("midrst_out_data", 32'(out_data), 32'h8000);
                rst_n = 1'b1;
            end
        end

        en = 1'b0; in_valid = 1'b0; underflow_clr = 1'b0;
        cycles(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
